// File: rtl/btn_irq_scheduler.sv
// Avalon-MM master servicing button PIO edge IRQs round-robin
// and queueing {source, level} events in a show-ahead FIFO.
module btn_irq_scheduler #(
  parameter int N_BTN      = 4,
  parameter int IDXW       = 2,
  parameter int FIFO_DEPTH = 8
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  enable,
  input  logic [N_BTN-1:0]      irq_in,
  output logic [1:0]            pio_address,
  output logic [N_BTN-1:0]      pio_chipselect,
  output logic                  pio_write_n,
  output logic [31:0]           pio_writedata,
  input  logic [32*N_BTN-1:0]   pio_readdata,
  output logic                  evt_valid,
  input  logic                  evt_ready,
  output logic [IDXW-1:0]       evt_src,
  output logic                  evt_level,
  output logic [7:0]            drop_count,
  output logic                  init_done
);

  localparam int AW = $clog2(FIFO_DEPTH);

  localparam logic [2:0] S_INIT = 3'd0;
  localparam logic [2:0] S_IDLE = 3'd1;
  localparam logic [2:0] S_CLR  = 3'd2;
  localparam logic [2:0] S_RD   = 3'd3;
  localparam logic [2:0] S_CAP  = 3'd4;

  logic [2:0]       state_q, state_d;
  logic [IDXW-1:0]  cnt_q, cnt_d;
  logic [IDXW-1:0]  gnt_q, gnt_d;
  logic [IDXW-1:0]  rr_q, rr_d;
  logic [IDXW-1:0]  gnt_sel;
  logic [IDXW-1:0]  rr_next;
  logic [1:0]       addr_q, addr_d;
  logic [N_BTN-1:0] cs_q, cs_d;
  logic             wn_q, wn_d;
  logic [31:0]      wd_q, wd_d;
  logic             init_q, init_d;
  logic [7:0]       drop_q;

  logic [IDXW:0]    mem_q [FIFO_DEPTH];
  logic [AW:0]      wr_q, rd_q;
  logic             full, empty, push, pop;
  logic             level;
  logic             rd_unused;

  // First pending source at or above rr_q, wrapping.
  always_comb begin
    logic [IDXW:0] pos;
    gnt_sel = '0;
    pos     = '0;
    for (int i = N_BTN - 1; i >= 0; i--) begin
      pos = {1'b0, rr_q} + (IDXW+1)'(i);
      if (pos >= (IDXW+1)'(N_BTN))
        pos = pos - (IDXW+1)'(N_BTN);
      if (irq_in[pos[IDXW-1:0]])
        gnt_sel = pos[IDXW-1:0];
    end
  end

  assign rr_next = (gnt_sel == IDXW'(N_BTN - 1))
                 ? '0 : gnt_sel + IDXW'(1);

  assign level     = pio_readdata[{gnt_q, 5'd0}];
  assign rd_unused = ^pio_readdata;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    gnt_d   = gnt_q;
    rr_d    = rr_q;
    addr_d  = 2'd0;
    cs_d    = '0;
    wn_d    = 1'b1;
    wd_d    = 32'd0;
    init_d  = init_q | (state_q == S_IDLE);
    unique case (state_q)
      S_INIT: begin
        cs_d   = N_BTN'(1) << cnt_q;
        addr_d = 2'd2;
        wd_d   = 32'd1;
        wn_d   = 1'b0;
        if (cnt_q == IDXW'(N_BTN - 1))
          state_d = S_IDLE;
        else
          cnt_d = cnt_q + IDXW'(1);
      end
      S_IDLE: begin
        if (enable && |irq_in) begin
          gnt_d   = gnt_sel;
          rr_d    = rr_next;
          state_d = S_CLR;
          cs_d    = N_BTN'(1) << gnt_sel;
          addr_d  = 2'd3;
          wd_d    = 32'd1;
          wn_d    = 1'b0;
        end
      end
      S_CLR: begin
        cs_d    = N_BTN'(1) << gnt_q;
        state_d = S_RD;
      end
      S_RD:  state_d = S_CAP;
      S_CAP: state_d = S_IDLE;
      default: state_d = S_INIT;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_INIT;
      cnt_q   <= '0;
      gnt_q   <= '0;
      rr_q    <= '0;
      addr_q  <= 2'd0;
      cs_q    <= '0;
      wn_q    <= 1'b1;
      wd_q    <= 32'd0;
      init_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      gnt_q   <= gnt_d;
      rr_q    <= rr_d;
      addr_q  <= addr_d;
      cs_q    <= cs_d;
      wn_q    <= wn_d;
      wd_q    <= wd_d;
      init_q  <= init_d;
    end
  end

  // Full is judged before any same-cycle pop.
  assign empty = (wr_q == rd_q);
  assign full  = (wr_q[AW] != rd_q[AW]) &&
                 (wr_q[AW-1:0] == rd_q[AW-1:0]);
  assign push  = (state_q == S_CAP) && !full;
  assign pop   = !empty && evt_ready;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_q   <= '0;
      rd_q   <= '0;
      drop_q <= 8'd0;
      for (int i = 0; i < FIFO_DEPTH; i++)
        mem_q[i] <= '0;
    end else begin
      if (push) begin
        mem_q[wr_q[AW-1:0]] <= {gnt_q, level};
        wr_q <= wr_q + (AW+1)'(1);
      end
      if (pop)
        rd_q <= rd_q + (AW+1)'(1);
      if ((state_q == S_CAP) && full && (drop_q != 8'hFF))
        drop_q <= drop_q + 8'd1;
    end
  end

  assign pio_address    = addr_q;
  assign pio_chipselect = cs_q;
  assign pio_write_n    = wn_q;
  assign pio_writedata  = wd_q;
  assign evt_valid      = !empty;
  assign {evt_src, evt_level} = mem_q[rd_q[AW-1:0]];
  assign drop_count     = drop_q;
  assign init_done      = init_q;

endmodule

// File: doc/btn_irq_scheduler.md
Name: btn_irq_scheduler

Overview:
- Avalon-MM master that owns N_BTN button PIO slaves; each slave has edge-capture IRQ, data register at address 0, irq_mask at address 2, and edge_capture at address 3 with write-1-to-clear.
- At start-up it enables every slave's irq_mask. It then round-robin arbitrates pending PIO IRQs, clears the capture, and reads the button level.
- Each serviced edge is queued as a {source, level} event in a show-ahead FIFO, consumed by CPU-side or LED logic without software polling.

Parameters:
- N_BTN, 4, number of PIO slaves served (2..16).
- IDXW, 2, source index width, equal to clog2(N_BTN).
- FIFO_DEPTH, 8, event FIFO entries (power of two, minimum 2).

Ports:
- clk  in  1  system clock.
- reset_n  in  1  asynchronous, active-low reset.
- enable  in  1  when 0, no new grant; a service already in progress completes.
- irq_in  in  N_BTN  per-slave IRQ, combinational from each slave.
- pio_address  out  2  shared slave address.
- pio_chipselect  out  N_BTN  one-hot slave select.
- pio_write_n  out  1  active-low write strobe, shared.
- pio_writedata  out  32  shared write data.
- pio_readdata  in  32*N_BTN  slave k readdata at bits [32k+31:32k]; each slave registers readdata from its address every clk, so read latency is 1.
- evt_valid  out  1  FIFO non-empty.
- evt_ready  in  1  consumer pop strobe, qualified by evt_valid.
- evt_src  out  IDXW  source index of the head event.
- evt_level  out  1  button level of the head event.
- drop_count  out  8  events lost to a full FIFO; saturates at 255.
- init_done  out  1  high once all irq_mask writes have been issued.

Behaviour:
- Reset values: pio_address=0, pio_chipselect=0, pio_write_n=1, pio_writedata=0, evt_valid=0, evt_src=0, evt_level=0, drop_count=0, init_done=0. The round-robin pointer is 0 and the FIFO is empty.
- All pio_* outputs are registered.
- FSM states: INIT, IDLE, CLR, RD, CAP.
- INIT:
  - One write per cycle, k=0..N_BTN-1: chipselect[k]=1, address=2, writedata=1, write_n=0. This takes N_BTN cycles.
  - irq_in is ignored during INIT.
  - After the last write: init_done<=1, go to IDLE.
- IDLE:
  - Buses are idle (chipselect=0, write_n=1).
  - If enable && |irq_in: grant = the first set bit of irq_in at or above rr_ptr, wrapping modulo N_BTN. Set rr_ptr<=grant+1 (mod N_BTN) and go to CLR.
- CLR: one cycle. chipselect[grant]=1, address=3, writedata=1, write_n=0. The slave's irq is low from the following cycle.
- RD: one cycle. chipselect[grant]=1, address=0, write_n=1.
- CAP:
  - Sample pio_readdata[32*grant] as the level.
  - If the FIFO is not full, push {grant, level}. Otherwise increment drop_count (saturating).
  - Go to IDLE.
- Service cost: 4 cycles per event (IDLE, CLR, RD, CAP). Because irq is already low in IDLE, the same edge is never serviced twice.
- Clear is issued before read: an edge arriving after the CLR cycle re-raises irq and is serviced again.
  - An edge detected in the same cycle as CLR is lost, because the slave gives clear priority. This is accepted behaviour.
- FIFO:
  - Show-ahead: evt_src and evt_level show the head entry whenever evt_valid=1.
  - Pop happens when evt_valid && evt_ready.
  - A push into an empty FIFO gives evt_valid=1 on the next cycle.
  - Full is evaluated before a same-cycle pop: a push while full is dropped even if a pop occurs in that cycle.
  - Pointers wrap modulo FIFO_DEPTH and use an extra bit to distinguish full from empty.
- Reset mid-operation returns all state to reset values and re-runs INIT. Any slave capture left set re-raises irq and is serviced after INIT.
- enable falling during CLR, RD or CAP does not abort the service.

Test Plan:
- Reset release, N_BTN=4 -> cycles 1-4 write address 2, writedata 1 to chipselect 0001, 0010, 0100, 1000 in order; init_done=1 on cycle 5.
- irq_in=0100 with slave 2 data=1 -> CLR to chipselect 0100 at address 3, RD at address 0, then evt_valid=1 with evt_src=2, evt_level=1, exactly 4 cycles after IDLE.
- irq_in=1111 held (slave model re-raises on each clear), rr_ptr=0 -> grants in order 0,1,2,3,0; each slave serviced once per round.
- evt_ready=0 and 10 events with FIFO_DEPTH=8 -> 8 entries queued, drop_count=2; then evt_ready=1 drains 8 entries in push order.
- enable=0 with irq_in=0001 -> no bus activity; enable=1 -> service starts the next cycle. enable deasserted during RD -> that event is still pushed.
- Slave edge injected in the CLR cycle -> that edge is lost and no second event occurs. Edge injected one cycle later -> a second event for the same source.
